bwt_mem_req_arbiter: RTL and testbench

- Shares the single occurrence-table memory request port between the forward and the backward SMEM control pipelines.
- Each requester issues a 42-bit addr_k/addr_l pair per lookup, tagged with its read number.
- The block queues each pair per requester and serialises them round-robin as two address beats, k then l, with valid/ready on the memory side.
- It raises a stall back to a requester pipeline when that requester's queue is full.

---
 rtl/bwt_mem_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_bwt_mem_req_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_mem_req_arbiter.sv
// rtl/bwt_mem_req_arbiter.sv - round-robin sharing of the occurrence-table request port between forward and backward SMEM pipelines
module bwt_mem_req_arbiter #(
   parameter int ADDR_W = 42,
   parameter int RN_W   = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_f,
   input  logic [ADDR_W-1:0] addr_k_f,
   input  logic [ADDR_W-1:0] addr_l_f,
   input  logic [RN_W-1:0]   read_num_f,
   output logic              stall_f,
   input  logic              req_valid_b,
   input  logic [ADDR_W-1:0] addr_k_b,
   input  logic [ADDR_W-1:0] addr_l_b,
   input  logic [RN_W-1:0]   read_num_b,
   output logic              stall_b,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [RN_W+1:0]   mem_tag,
   input  logic              mem_ready,
   output logic              busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} state_t;

   // Index 0 is the forward requester, index 1 the backward one.
   logic [ADDR_W-1:0] q_k    [2][DEPTH];
   logic [ADDR_W-1:0] q_l    [2][DEPTH];
   logic [RN_W-1:0]   q_rn   [2][DEPTH];
   logic [PW-1:0]     wr_ptr [2];
   logic [PW-1:0]     rd_ptr [2];
   logic [CW-1:0]     count  [2];

   logic [ADDR_W-1:0] in_k   [2];
   logic [ADDR_W-1:0] in_l   [2];
   logic [RN_W-1:0]   in_rn  [2];
   logic [1:0]        req_v;
   logic [1:0]        full;
   logic [1:0]        push;
   logic [1:0]        pop;
   logic [1:0]        elig;
   logic [PW-1:0]     head   [2];

   state_t            state;
   logic              grant;
   logic              last_grant;
   logic              sel;
   logic              any_elig;
   logic [ADDR_W-1:0] sel_k;
   logic [RN_W-1:0]   sel_rn;

   // Gather both requesters into indexed form
   always_comb begin
      in_k[0]  = addr_k_f;
      in_l[0]  = addr_l_f;
      in_rn[0] = read_num_f;
      in_k[1]  = addr_k_b;
      in_l[1]  = addr_l_b;
      in_rn[1] = read_num_b;
      req_v    = {req_valid_b, req_valid_f};
   end

   // Stall comes from the registered count only, so a same-cycle pop never frees a slot early
   assign full[0] = (count[0] == CW'(DEPTH));
   assign full[1] = (count[1] == CW'(DEPTH));
   assign stall_f = full[0];
   assign stall_b = full[1];
   assign busy    = (state != IDLE) || (count[0] != '0) || (count[1] != '0);

   // Push/pop strobes, post-pop eligibility and the next grant with its head entry
   always_comb begin
      for (int r = 0; r < 2; r++) begin
         push[r] = rst & req_v[r] & ~full[r];
         pop[r]  = (state == ISSUE_L) & mem_ready & (grant == 1'(r));
         elig[r] = (count[r] - CW'(pop[r])) != '0;
         head[r] = rd_ptr[r] + PW'(pop[r]);
      end
      any_elig = |elig;
      sel      = (&elig) ? ~last_grant : elig[1];
      sel_k    = q_k[sel][head[sel]];
      sel_rn   = q_rn[sel][head[sel]];
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < 2; r++) begin
            wr_ptr[r] <= '0;
            rd_ptr[r] <= '0;
            count[r]  <= '0;
         end
      end else begin
         for (int r = 0; r < 2; r++) begin
            if (push[r]) wr_ptr[r] <= wr_ptr[r] + PW'(1);
            if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PW'(1);
            count[r] <= count[r] + CW'(push[r]) - CW'(pop[r]);
         end
      end
   end

   // Entry storage, written on accepted pushes only
   always_ff @(posedge clk) begin
      for (int r = 0; r < 2; r++) begin
         if (push[r]) begin
            q_k[r][wr_ptr[r]]  <= in_k[r];
            q_l[r][wr_ptr[r]]  <= in_l[r];
            q_rn[r][wr_ptr[r]] <= in_rn[r];
         end
      end
   end

   // Beat sequencer: k beat then l beat of the granted head, next grant loaded on the l handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_tag    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_elig) begin
                  grant      <= sel;
                  last_grant <= sel;
                  mem_valid  <= 1'b1;
                  mem_addr   <= sel_k;
                  mem_tag    <= {sel, 1'b0, sel_rn};
                  state      <= ISSUE_K;
               end
            end
            ISSUE_K: begin
               if (mem_ready) begin
                  mem_addr <= q_l[grant][rd_ptr[grant]];
                  mem_tag  <= {grant, 1'b1, q_rn[grant][rd_ptr[grant]]};
                  state    <= ISSUE_L;
               end
            end
            ISSUE_L: begin
               if (mem_ready) begin
                  if (any_elig) begin
                     grant      <= sel;
                     last_grant <= sel;
                     mem_addr   <= sel_k;
                     mem_tag    <= {sel, 1'b0, sel_rn};
                     state      <= ISSUE_K;
                  end else begin
                     mem_valid <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            default: begin
               mem_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bwt_mem_req_arbiter.sv
// tb/tb_bwt_mem_req_arbiter.sv - self-checking bench for bwt_mem_req_arbiter
module tb_bwt_mem_req_arbiter;
   localparam int ADDR_W = 42;
   localparam int RN_W   = 8;
   localparam int DEPTH  = 4;
   localparam int TW     = RN_W + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid_f, req_valid_b;
   logic [ADDR_W-1:0] addr_k_f, addr_l_f, addr_k_b, addr_l_b;
   logic [RN_W-1:0]   read_num_f, read_num_b;
   logic              stall_f, stall_b;
   logic              mem_valid, mem_ready, busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [TW-1:0]     mem_tag;

   always #5 clk = ~clk;

   bwt_mem_req_arbiter #(.ADDR_W(ADDR_W), .RN_W(RN_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid_f(req_valid_f), .addr_k_f(addr_k_f), .addr_l_f(addr_l_f),
      .read_num_f(read_num_f), .stall_f(stall_f),
      .req_valid_b(req_valid_b), .addr_k_b(addr_k_b), .addr_l_b(addr_l_b),
      .read_num_b(read_num_b), .stall_b(stall_b),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_tag(mem_tag),
      .mem_ready(mem_ready), .busy(busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference model: one FIFO of outstanding lookups per requester
   typedef struct packed {
      logic [ADDR_W-1:0] k;
      logic [ADDR_W-1:0] l;
      logic [RN_W-1:0]   rn;
   } ent_t;

   ent_t              mq_f[$];
   ent_t              mq_b[$];
   ent_t              h, e;
   logic              expect_l = 1'b0;
   logic              pair_src = 1'b0;
   logic              prev_hold = 1'b0;
   logic [ADDR_W-1:0] prev_addr;
   logic [TW-1:0]     prev_tag;
   logic              msrc;
   logic              full_fm, full_bm;
   int                pairs_done = 0;

   // Monitor, sampling mid-cycle just before the active edge
   always begin
      @(negedge clk);
      #3;
      if (!rst) begin
         mq_f.delete();
         mq_b.delete();
         expect_l  = 1'b0;
         prev_hold = 1'b0;
      end else begin
         full_fm = (mq_f.size() == DEPTH);
         full_bm = (mq_b.size() == DEPTH);
         chk("stall_f", 64'(stall_f), 64'(full_fm));
         chk("stall_b", 64'(stall_b), 64'(full_bm));
         if (prev_hold) begin
            chk("hold_valid", 64'(mem_valid), 64'(1));
            chk("hold_addr", 64'(mem_addr), 64'(prev_addr));
            chk("hold_tag", 64'(mem_tag), 64'(prev_tag));
         end
         if (mem_valid) begin
            msrc = mem_tag[TW-1];
            if ((msrc && mq_b.size() == 0) || (!msrc && mq_f.size() == 0)) begin
               chk("beat_from_empty_queue", 64'(mem_tag), 64'(0));
               chk("beat_valid_without_entry", 64'(mem_valid), 64'(0));
            end else begin
               h = msrc ? mq_b[0] : mq_f[0];
               if (!mem_tag[TW-2]) begin
                  chk("k_order", 64'(expect_l), 64'(0));
                  chk("k_addr", 64'(mem_addr), 64'(h.k));
                  chk("k_rn", 64'(mem_tag[RN_W-1:0]), 64'(h.rn));
                  if (mem_ready) begin
                     expect_l = 1'b1;
                     pair_src = msrc;
                  end
               end else begin
                  chk("l_order", 64'(expect_l), 64'(1));
                  chk("l_src", 64'(msrc), 64'(pair_src));
                  chk("l_addr", 64'(mem_addr), 64'(h.l));
                  chk("l_rn", 64'(mem_tag[RN_W-1:0]), 64'(h.rn));
                  if (mem_ready) begin
                     if (msrc) void'(mq_b.pop_front());
                     else      void'(mq_f.pop_front());
                     expect_l = 1'b0;
                     pairs_done++;
                  end
               end
            end
         end
         prev_hold = mem_valid && !mem_ready;
         prev_addr = mem_addr;
         prev_tag  = mem_tag;
         if (req_valid_f && !full_fm) begin
            e.k = addr_k_f; e.l = addr_l_f; e.rn = read_num_f;
            mq_f.push_back(e);
         end
         if (req_valid_b && !full_bm) begin
            e.k = addr_k_b; e.l = addr_l_b; e.rn = read_num_b;
            mq_b.push_back(e);
         end
      end
   end

   // Per-cycle vectors: inputs for this cycle and outputs expected to be visible in it
   typedef struct {
      logic              vf;
      logic [ADDR_W-1:0] kf, lf;
      logic [RN_W-1:0]   rf;
      logic              vb;
      logic [ADDR_W-1:0] kb, lb;
      logic [RN_W-1:0]   rb;
      logic              rdy;
      logic              ev;
      logic [ADDR_W-1:0] ea;
      logic [TW-1:0]     et;
      logic              eb;
   } vec_t;

   function automatic vec_t mk(int vf, int kf, int lf, int rf, int vb, int kb, int lb, int rb,
                               int rdy, int ev, int ea, int et, int eb);
      vec_t v;
      v.vf = vf[0]; v.kf = ADDR_W'(kf); v.lf = ADDR_W'(lf); v.rf = RN_W'(rf);
      v.vb = vb[0]; v.kb = ADDR_W'(kb); v.lb = ADDR_W'(lb); v.rb = RN_W'(rb);
      v.rdy = rdy[0]; v.ev = ev[0]; v.ea = ADDR_W'(ea); v.et = TW'(et); v.eb = eb[0];
      return v;
   endfunction

   task automatic idle_inputs();
      req_valid_f = 1'b0; addr_k_f = '0; addr_l_f = '0; read_num_f = '0;
      req_valid_b = 1'b0; addr_k_b = '0; addr_l_b = '0; read_num_b = '0;
   endtask

   task automatic push_f(input int k, input int l, input int rn);
      req_valid_f = 1'b1; addr_k_f = ADDR_W'(k); addr_l_f = ADDR_W'(l); read_num_f = RN_W'(rn);
   endtask

   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      idle_inputs();
      mem_ready = 1'b1;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         done = (mq_f.size() == 0) && (mq_b.size() == 0) && !mem_valid && !busy;
      end
      chk(name, 64'(done), 64'(1));
   endtask

   vec_t tbl[17];
   int   acc, p0;
   bit   last_ok, found;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = mk(1, 'h100, 'h101, 1, 1, 'h200, 'h201, 2, 1, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h100, 'h001, 1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h101, 'h101, 1);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h200, 'h202, 1);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h201, 'h302, 1);
      tbl[6]  = mk(1, 'h10, 'h20, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h10, 'h003, 1);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h20, 'h103, 1);
      tbl[10] = mk(1, 'h30, 'h31, 4, 1, 'h40, 'h41, 5, 1, 0, 0, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h40, 'h205, 1);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h41, 'h305, 1);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h30, 'h004, 1);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h31, 'h104, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      rst = 1'b0;
      mem_ready = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_mem_valid", 64'(mem_valid), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_tag", 64'(mem_tag), 64'(0));
      chk("rst_stall_f", 64'(stall_f), 64'(0));
      chk("rst_stall_b", 64'(stall_b), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      rst = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);

      // Tie after reset (F first), single request, then tie with last grant F (B first)
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), 64'(mem_valid), 64'(tbl[i].ev));
         chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].eb));
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(tbl[i].ea));
            chk($sformatf("vec%0d_tag", i), 64'(mem_tag), 64'(tbl[i].et));
         end
         req_valid_f = tbl[i].vf; addr_k_f = tbl[i].kf; addr_l_f = tbl[i].lf; read_num_f = tbl[i].rf;
         req_valid_b = tbl[i].vb; addr_k_b = tbl[i].kb; addr_l_b = tbl[i].lb; read_num_b = tbl[i].rb;
         mem_ready = tbl[i].rdy;
      end

      // Backpressure on a k beat for 5 cycles
      @(negedge clk);
      mem_ready = 1'b0;
      push_f('h55, 'h66, 9);
      @(negedge clk);
      idle_inputs();
      chk("bp_latency_valid", 64'(mem_valid), 64'(0));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(mem_valid), 64'(1));
         chk("bp_hold_addr", 64'(mem_addr), 64'(42'h55));
         chk("bp_hold_tag", 64'(mem_tag), 64'(10'h009));
      end
      @(negedge clk);
      chk("bp_last_k_addr", 64'(mem_addr), 64'(42'h55));
      mem_ready = 1'b1;
      @(negedge clk);
      chk("bp_l_valid", 64'(mem_valid), 64'(1));
      chk("bp_l_addr", 64'(mem_addr), 64'(42'h66));
      chk("bp_l_tag", 64'(mem_tag), 64'(10'h109));
      @(negedge clk);
      chk("bp_done_valid", 64'(mem_valid), 64'(0));

      // Full forward queue with memory stalled, then release
      p0 = pairs_done;
      mem_ready = 1'b0;
      acc = 0;
      last_ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c > 0 && last_ok) acc++;
         push_f('h1000 + acc, 'h2000 + acc, acc);
         last_ok = !stall_f;
      end
      chk("full_accepted", 64'(acc), 64'(DEPTH));
      chk("full_stall_f", 64'(stall_f), 64'(1));
      @(negedge clk);
      chk("full_hold_stall", 64'(stall_f), 64'(1));
      mem_ready = 1'b1;
      @(negedge clk);
      chk("full_l_cycle_stall", 64'(stall_f), 64'(1));
      @(negedge clk);
      chk("full_release_stall", 64'(stall_f), 64'(0));
      @(negedge clk);
      idle_inputs();
      chk("full_refill_stall", 64'(stall_f), 64'(1));
      drain("full_drain");
      chk("full_pairs_issued", 64'(pairs_done - p0), 64'(DEPTH + 1));

      // Reset during an l beat with entries still queued
      @(negedge clk);
      push_f('h700, 'h701, 'h70);
      req_valid_b = 1'b1; addr_k_b = 42'h800; addr_l_b = 42'h801; read_num_b = 8'h80;
      @(negedge clk);
      push_f('h710, 'h711, 'h71);
      req_valid_b = 1'b0;
      @(negedge clk);
      idle_inputs();
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         found = mem_valid && mem_tag[TW-2];
      end
      chk("rmid_found_l_beat", 64'(found), 64'(1));
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rmid_valid", 64'(mem_valid), 64'(0));
      chk("rmid_busy", 64'(busy), 64'(0));
      chk("rmid_stall_f", 64'(stall_f), 64'(0));
      chk("rmid_stall_b", 64'(stall_b), 64'(0));
      chk("rmid_addr", 64'(mem_addr), 64'(0));
      chk("rmid_tag", 64'(mem_tag), 64'(0));
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rmid_no_stale_valid", 64'(mem_valid), 64'(0));
         chk("rmid_no_stale_busy", 64'(busy), 64'(0));
      end

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         req_valid_f = 1'($urandom_range(0, 1));
         addr_k_f    = ADDR_W'({$urandom(), $urandom()});
         addr_l_f    = ADDR_W'({$urandom(), $urandom()});
         read_num_f  = RN_W'($urandom());
         req_valid_b = 1'($urandom_range(0, 1));
         addr_k_b    = ADDR_W'({$urandom(), $urandom()});
         addr_l_b    = ADDR_W'({$urandom(), $urandom()});
         read_num_b  = RN_W'($urandom());
         mem_ready   = ($urandom_range(0, 9) < 7);
      end
      drain("random_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
